// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issue controller and the iterative mul/div unit.
// The controller drives the request side and the unit drives status and the HI/LO registers.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Every operation takes 32 CALC cycles plus one FIX cycle for sign correction.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [DW-1:0]    acc_r, acc_s;
    logic [WIDTH-1:0] opb_r, opb_s;
    logic [WIDTH-1:0] araw_r, araw_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic             is_div_r, is_div_s;
    logic             is_signed_r, is_signed_s;
    logic             sign_a_r, sign_a_s;
    logic             sign_b_r, sign_b_s;
    logic             div0_r, div0_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;

    // Operand conditioning for the accepting edge: magnitudes for signed ops.
    logic             req_signed_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    assign req_signed_s = (bus.Op == 3'd0) || (bus.Op == 3'd2);
    assign abs_a_s = (req_signed_s && bus.A[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.A) : bus.A;
    assign abs_b_s = (req_signed_s && bus.B[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.B) : bus.B;

    // acc holds {partial_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    logic [WIDTH:0]   mul_add_s;
    logic [DW-1:0]    mul_nxt_s;
    logic [WIDTH:0]   trial_s;
    logic [DW-1:0]    div_nxt_s;
    assign mul_add_s = {1'b0, acc_r[DW-1:WIDTH]} + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    assign mul_nxt_s = {mul_add_s, acc_r[WIDTH-1:1]};
    assign trial_s   = {acc_r[DW-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opb_r};
    assign div_nxt_s = trial_s[WIDTH] ? {acc_r[DW-2:WIDTH-1], acc_r[WIDTH-2:0], 1'b0}
                                      : {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIX; the remainder follows the dividend's sign.
    logic             neg_res_s;
    logic [DW-1:0]    prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
    assign neg_res_s  = is_signed_r && (sign_a_r ^ sign_b_r);
    assign prod_fix_s = neg_res_s ? ({DW{1'b0}} - acc_r) : acc_r;
    assign quo_fix_s  = neg_res_s ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    assign rem_fix_s  = (is_signed_r && sign_a_r) ? ({WIDTH{1'b0}} - acc_r[DW-1:WIDTH])
                                                  : acc_r[DW-1:WIDTH];

    // Next-state, datapath and output decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        acc_s       = acc_r;
        opb_s       = opb_r;
        araw_s      = araw_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        is_div_s    = is_div_r;
        is_signed_s = is_signed_r;
        sign_a_s    = sign_a_r;
        sign_b_s    = sign_b_r;
        div0_s      = div0_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_s     = CALC;
                            cnt_s       = {CNT_W{1'b0}};
                            is_div_s    = bus.Op[1];
                            is_signed_s = req_signed_s;
                            sign_a_s    = req_signed_s && bus.A[WIDTH-1];
                            sign_b_s    = req_signed_s && bus.B[WIDTH-1];
                            div0_s      = bus.Op[1] && (bus.B == {WIDTH{1'b0}});
                            araw_s      = bus.A;
                            if (bus.Op[1]) begin
                                acc_s = {{WIDTH{1'b0}}, abs_a_s};
                                opb_s = abs_b_s;
                            end else begin
                                acc_s = {{WIDTH{1'b0}}, abs_b_s};
                                opb_s = abs_a_s;
                            end
                        end
                        3'd4: begin
                            hi_s = bus.A;
                        end
                        3'd5: begin
                            lo_s = bus.A;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                acc_s = is_div_r ? div_nxt_s : mul_nxt_s;
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == {CNT_W{1'b1}}) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                state_s = IDLE;
                done_s  = 1'b1;
                cnt_s   = {CNT_W{1'b0}};
                if (!is_div_r) begin
                    hi_s = prod_fix_s[DW-1:WIDTH];
                    lo_s = prod_fix_s[WIDTH-1:0];
                end else if (div0_r) begin
                    hi_s = araw_r;
                    lo_s = {WIDTH{1'b1}};
                end else begin
                    hi_s = rem_fix_s;
                    lo_s = quo_fix_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= {DW{1'b0}};
            opb_r       <= {WIDTH{1'b0}};
            araw_r      <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            div0_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            opb_r       <= opb_s;
            araw_r      <= araw_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            is_div_r    <= is_div_s;
            is_signed_r <= is_signed_s;
            sign_a_r    <= sign_a_s;
            sign_b_r    <= sign_b_s;
            div0_r      <= div0_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.Busy = busy_r;
    assign bus.Done = done_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of MULT/DIV cases plus hand-written
// sequences for reset mid-operation, ignored requests, MTHI/MTLO and back-to-back issue.
module tb_mul_div_unit;
    logic clk;
    logic reset;
    mul_div_unit_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t        vecs[12];
    int          n_pass;
    int          n_total;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called #1 after the accepting edge; ends #1 after edge 33.
    task automatic track(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit inject);
        int busy_cnt;
        bit done_early;
        bit hold_ok;
        busy_cnt   = 0;
        done_early = 1'b0;
        hold_ok    = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (bus.Busy) busy_cnt++;
            if (bus.Done) done_early = 1'b1;
            if (bus.HI !== cur_hi || bus.LO !== cur_lo) hold_ok = 1'b0;
            if (inject && k == 5) begin
                bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'h0000_AAAA;
            end
            if (inject && k == 6) bus.Start = 1'b0;
            @(posedge clk); #1;
        end
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, " no_early_done_and_hold"}, {62'd0, done_early, hold_ok}, 64'd1);
        check({name, " idle_done"}, {62'd0, bus.Busy, bus.Done}, 64'd1);
        check({name, " hi_lo"}, {bus.HI, bus.LO}, {ehi, elo});
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    // Presents a request at a negedge; returns #1 after the accepting edge with inputs scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Op = 3'($urandom);
        bus.A  = $urandom;
        bus.B  = $urandom;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        bus.Start = 1'b0; bus.Op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
        vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, "divu_fff9_2"};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_wrap"};
        vecs[5]  = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
        vecs[6]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[7]  = '{3'd0, 32'h0000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, "mult_5xneg4"};
        vecs[8]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2"};
        vecs[9]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100_7"};
        vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
        vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_2p32"};

        reset = 1'b1;
        #12;
        check("reset_state", {bus.Busy, bus.Done, bus.HI, bus.LO}, {2'b00, 64'd0});
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-operation, with HI preloaded so the clear is visible.
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'h0000_1111;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("mthi_preload", {bus.HI, bus.Busy}, {32'h0000_1111, 1'b0});
        issue(3'd1, 32'd5, 32'd7);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_midop", {bus.Busy, bus.HI, bus.LO}, {1'b0, 64'd0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit seen_done;
            seen_done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (bus.Done || bus.Busy) seen_done = 1'b1;
            end
            check("no_done_after_reset", {63'd0, seen_done}, 64'd0);
        end

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            track(vecs[i].name, vecs[i].hi, vecs[i].lo, 1'b0);
            @(posedge clk); #1;
            check({vecs[i].name, " done_pulse_end"}, {63'd0, bus.Done}, 64'd0);
        end

        // MTHI during a MULT is dropped; the product lands in HI.
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        track("mult_ignore_mthi", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 3'd5; bus.A = 32'h0000_0055;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("mtlo_write", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'h0000_0055});
        check("mtlo_no_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
        @(posedge clk); #1;
        check("mtlo_no_late_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
        cur_lo = 32'h0000_0055;

        // Start held through Done: the second MULTU is accepted on the Done edge.
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
        @(posedge clk); #1;
        track("b2b_first", 32'd0, 32'd12, 1'b0);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("b2b_second_accepted", {62'd0, bus.Busy, bus.Done}, 64'd2);
        track("b2b_second", 32'd0, 32'd12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers.
- Sits beside the ALU in the execute path. It consumes the two register-file read values (RD1/RD2) and produces HI/LO.
- HI/LO are then selected by MFHI/MFLO onto the register-file write-data input (Din).
- The controller uses Busy to stall instruction issue while an operation runs.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Start  input  1  request pulse; sampled on a clk edge only while idle
Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (no effect)
A  input  32  operand rs (multiplicand/dividend; also source for MTHI/MTLO)
B  input  32  operand rt (multiplier/divisor)
Busy  output  1  high while an iterative operation is in progress
Done  output  1  one-cycle pulse: HI/LO have just been updated by MULT/DIV
HI  output  32  HI register (product high word / remainder)
LO  output  32  LO register (product low word / quotient)

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, counter=0, HI=LO=0, Busy=0, Done=0.
  - Internal operand/partial registers are cleared.
  - An in-flight result is discarded.
- States: IDLE, CALC, FIX. Busy = (state != IDLE).
- Start is accepted only in IDLE.
  - Op 0-3 on accepting edge: latch |A|,|B| (signed ops) or A,B (unsigned ops), latch sign bits, go to CALC, counter=0.
  - Op 4 (MTHI) on accepting edge: HI<=A, stay IDLE, no Busy, no Done. Op 5 (MTLO): same with LO.
  - Op 6/7: ignored.
- CALC:
  - Multiply: one shift-add step per cycle, radix 2, 64-bit partial product.
  - Divide: one restoring step per cycle.
  - Counter increments each edge; after the edge with counter==31, go to FIX. Exactly 32 CALC cycles.
- FIX (one cycle):
  - Apply sign correction: signed product negated if signA^signB; signed quotient negated if signA^signB; signed remainder takes the sign of the dividend.
  - Write HI/LO on the FIX->IDLE edge.
  - Done=1 for exactly the following cycle.
- Timing: accepting edge = edge 0. Busy is high for the 33 cycles after edge 0. HI/LO change on edge 33. Done is high during the cycle after edge 33.
- Start while Busy (any Op, including MTHI/MTLO): ignored, no effect. The controller must hold it.
- HI/LO hold their values while Busy; they change only on the FIX edge or on MTHI/MTLO.
- Arithmetic is modulo 2^32 per word. Product = full 64-bit result {HI,LO}.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=A as originally presented. Sign fixup is skipped and the unit still takes the full 33-cycle latency with Done.
- Start asserted in the same cycle as Done (state IDLE): accepted normally.
- A/B/Op may change after the accepting edge without affecting the result.

Test Plan:
- Reset mid-op: MULTU A=5, B=7, reset asserted asynchronously at CALC cycle 10 -> Busy=0, HI=LO=0 immediately; no Done follows.
- MULTU/MULT: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after edge 33 HI=0xFFFFFFFE, LO=0x00000001, Done one cycle, Busy high exactly 33 cycles. MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed/unsigned divide: DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- Corner divides: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234.
- Ignored requests while Busy: during a MULT, pulse Start with Op=MTHI, A=0xAAAA -> ignored; HI shows the product afterward. Then while idle, MTLO A=0x55 -> LO=0x55 on the next edge, Busy stays 0, no Done.
- Back-to-back: Start with MULTU 3x4 held through the Done cycle -> a second operation is accepted on that edge; the second Done follows 34 edges later with LO=12.
